// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, req/ack instruction memory
// handshake, and a small {pc,instr} buffer feeding the IF/ID register.
//
//   state | meaning
//   IDLE  | no request outstanding (buffer full or just redirected)
//   WAIT  | request on imem_addr outstanding, response will be buffered
//   KILL  | stale request outstanding after a redirect, response discarded
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, KILL} stateT;

  stateT              state;
  stateT              stateNext;
  logic [31:0]        nextPc;
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     countSum;
  logic               push;
  logic               pop;
  logic               room;
  logic               issue;
  logic [31:0]        pcMem    [FIFO_DEPTH];
  logic [31:0]        instrMem [FIFO_DEPTH];

  assign imem_req = (state != IDLE);
  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? pcMem[rdPtr] : 32'h0;
  assign if_pc4   = if_pc + 32'd4;
  assign if_instr = if_valid ? instrMem[rdPtr] : NOP;

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    push      = imem_req & imem_ack & (state == WAIT) & ~redirect;
    pop       = if_valid & ~stall;
    countSum  = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
    room      = countSum < (CNT_W+1)'(FIFO_DEPTH);
    case (state)
      IDLE: begin
        if (!redirect && room) begin
          stateNext = WAIT;
          issue     = 1'b1;
        end
      end
      WAIT: begin
        if (redirect) begin
          stateNext = imem_ack ? IDLE : KILL;
        end else if (imem_ack) begin
          if (room) issue = 1'b1;
          else      stateNext = IDLE;
        end
      end
      KILL: begin
        if (imem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      nextPc    <= RESET_PC;
      imem_addr <= 32'h0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
    end else begin
      state <= stateNext;
      if (redirect) begin
        // Redirect wins over everything: flush the buffer and retarget.
        nextPc <= redirect_pc;
        rdPtr  <= '0;
        wrPtr  <= '0;
        count  <= '0;
      end else begin
        if (issue) begin
          imem_addr <= nextPc;
          nextPc    <= nextPc + 32'd4;
        end
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)  rdPtr <= rdPtr + PTR_W'(1);
        count <= countSum[CNT_W-1:0];
      end
    end
  end

  // Buffer storage needs no reset; entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr]    <= imem_addr;
      instrMem[wrPtr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model, expected-PC scoreboard
// checked at the IF/ID boundary, and a request-stability monitor.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;

  int          checks = 0;
  int          failures = 0;
  int          memLat = 0;
  int          waitCnt = 0;
  int          sbPops = 0;
  logic [31:0] sbQ [$];
  logic [31:0] sbExp;
  logic        pRst = 1'b0;
  logic        pReq = 1'b0;
  logic        pAck = 1'b0;
  logic [31:0] pAddr = 32'h0;

  fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // memLat = wait cycles before ack; 0 acks in the cycle the request rises.
  assign imem_ack   = imem_req && (waitCnt >= memLat);
  assign imem_rdata = memFn(imem_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst)                       waitCnt <= 0;
    else if (imem_req && imem_ack)  waitCnt <= 0;
    else if (imem_req)              waitCnt <= waitCnt + 1;
    else                            waitCnt <= 0;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sbLoad(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sbQ.push_back(base + 32'(4 * i));
  endtask

  task automatic resetChecks(input string pfx);
    checkVal({pfx, "_req"},   32'(imem_req), 32'd0);
    checkVal({pfx, "_addr"},  imem_addr, 32'h0);
    checkVal({pfx, "_valid"}, 32'(if_valid), 32'd0);
    checkVal({pfx, "_pc"},    if_pc, 32'h0);
    checkVal({pfx, "_pc4"},   if_pc4, 32'h4);
    checkVal({pfx, "_instr"}, if_instr, NOP);
  endtask

  task automatic startRun(input int lat, input logic stallInit);
    rst = 1'b0;
    redirect = 1'b0;
    stall = stallInit;
    memLat = lat;
    sbQ.delete();
    sbPops = 0;
    tick();
    tick();
    rst = 1'b1;
    sbLoad(32'h100, 64);
  endtask

  // Scoreboard at the IF/ID boundary plus request hold monitor.
  always @(negedge clk) begin
    if (rst && !redirect) begin
      if (if_valid && !stall) begin
        if (sbQ.size() == 0) begin
          checkVal("sbUnderflow", 32'(sbQ.size()), 32'd1);
        end else begin
          sbExp = sbQ.pop_front();
          sbPops++;
          checkVal("sbPc",    if_pc,    sbExp);
          checkVal("sbPc4",   if_pc4,   sbExp + 32'd4);
          checkVal("sbInstr", if_instr, memFn(sbExp));
        end
      end else if (!if_valid) begin
        checkVal("emptyPc",    if_pc,    32'h0);
        checkVal("emptyPc4",   if_pc4,   32'h4);
        checkVal("emptyInstr", if_instr, NOP);
      end
    end
    if (rst && pRst && pReq && !pAck) begin
      checkVal("reqHold",  32'(imem_req), 32'd1);
      checkVal("addrHold", imem_addr, pAddr);
    end
    pRst  <= rst;
    pReq  <= imem_req;
    pAck  <= imem_ack;
    pAddr <= imem_addr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 rst = 1'b0;
    #1 resetChecks("rst0");

    // Zero-wait: first entry visible after the second edge following release.
    startRun(0, 1'b0);
    tick();
    checkVal("t1Req",   32'(imem_req), 32'd1);
    checkVal("t1Addr",  imem_addr, 32'h100);
    checkVal("t1Valid", 32'(if_valid), 32'd0);
    tick();
    checkVal("t1Pc0", if_pc, 32'h100);
    tick();
    checkVal("t1Pc1", if_pc, 32'h104);
    tick();
    checkVal("t1Pc2", if_pc, 32'h108);
    repeat (10) tick();
    checkVal("t1Seen", 32'(sbPops >= 10), 32'd1);

    // Three wait cycles per access: one delivered entry every four cycles.
    startRun(3, 1'b0);
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    checkVal("t2Start", 32'(if_valid), 32'd1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (if_valid) n++;
      tick();
    end
    checkVal("t2Rate", 32'(n), 32'd4);

    // ID stalled: buffer fills, requests stop, release drains with no gap.
    startRun(0, 1'b1);
    repeat (6) tick();
    checkVal("t3ReqIdle", 32'(imem_req), 32'd0);
    checkVal("t3Head",    if_pc, 32'h100);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkVal("t3NoGap", 32'(if_valid), 32'd1);
      tick();
    end
    checkVal("t3Seen", 32'(sbPops >= 5), 32'd1);

    // Redirect while waiting on 0x10C: stale response dropped via KILL.
    startRun(3, 1'b0);
    for (int i = 0; i < 60 && !(imem_req && imem_addr == 32'h10C && waitCnt == 1); i++) tick();
    checkVal("t4Reach", imem_addr, 32'h10C);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    sbQ.delete();
    sbLoad(32'h200, 32);
    tick();
    redirect = 1'b0;
    checkVal("t4KillReq",   32'(imem_req), 32'd1);
    checkVal("t4KillAddr",  imem_addr, 32'h10C);
    checkVal("t4Flushed",   32'(if_valid), 32'd0);
    for (int i = 0; i < 30 && !if_valid; i++) tick();
    checkVal("t4FirstPc", if_pc, 32'h200);
    sbPops = 0;
    repeat (12) tick();
    checkVal("t4Seen", 32'(sbPops >= 2), 32'd1);

    // Redirect in the same cycle as ack: acked word dropped, refetch target.
    startRun(0, 1'b0);
    repeat (5) tick();
    checkVal("t5Busy", 32'(imem_req), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    sbQ.delete();
    sbLoad(32'h300, 16);
    tick();
    redirect = 1'b0;
    checkVal("t5Idle",    32'(imem_req), 32'd0);
    checkVal("t5Flushed", 32'(if_valid), 32'd0);
    tick();
    checkVal("t5Req",  32'(imem_req), 32'd1);
    checkVal("t5Addr", imem_addr, 32'h300);
    sbPops = 0;
    repeat (6) tick();
    checkVal("t5Seen", 32'(sbPops >= 4), 32'd1);

    // PC wrap at the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    sbQ.delete();
    sbLoad(32'hFFFF_FFF8, 16);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 20 && !(if_valid && if_pc == 32'hFFFF_FFFC); i++) tick();
    checkVal("t6PcTop", if_pc,  32'hFFFF_FFFC);
    checkVal("t6Pc4",   if_pc4, 32'h0);
    tick();
    checkVal("t6PcWrap", if_pc, 32'h0);
    sbPops = 0;
    repeat (4) tick();
    checkVal("t6Seen", 32'(sbPops >= 4), 32'd1);

    // Reset asserted mid-WAIT: outputs return to reset values at once.
    startRun(3, 1'b0);
    repeat (6) tick();
    for (int i = 0; i < 20 && !(imem_req && waitCnt == 1); i++) tick();
    checkVal("t7InWait", 32'(imem_req), 32'd1);
    rst = 1'b0;
    #1;
    resetChecks("t7Rst");
    tick();
    tick();
    sbQ.delete();
    rst = 1'b1;
    sbLoad(32'h100, 16);
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    checkVal("t7Refetch", if_pc, 32'h100);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
